// File: rtl/ksa_engine_if.sv
// ksa_engine_if: handshake and RAM bus bundle for the RC4 key-scheduling engine.
//   start/init_only/secret_key : run request and its operands (from the requester)
//   busy/done                  : run status (from the engine)
//   ram_addr/ram_wdata/ram_wren: single-port RAM command (from the engine)
//   ram_q                      : RAM read data, one wait state (from the RAM)
// The slave modport is the engine's view; master is the requester/RAM side.
interface ksa_engine_if #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned ADDR_W    = 8
) ();
  logic                   start;
  logic                   init_only;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic                   busy;
  logic                   done;
  logic [ADDR_W-1:0]      ram_addr;
  logic [ADDR_W-1:0]      ram_wdata;
  logic                   ram_wren;
  logic [ADDR_W-1:0]      ram_q;

  modport slave (
    input  start, init_only, secret_key, ram_q,
    output busy, done, ram_addr, ram_wdata, ram_wren
  );

  modport master (
    output start, init_only, secret_key, ram_q,
    input  busy, done, ram_addr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling algorithm driving an external single-port RAM.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : ksa_engine_if.slave
//         start/init_only/secret_key sampled in idle or done
//         busy high while a run is in progress, done held until next start or reset
//         ram_addr/ram_wdata/ram_wren registered RAM command, ram_q read data
// Each state's action happens on the clock edge taken while in that state, so the RAM
// command it issues is visible during the following cycle. ram_q is sampled two edges
// after the address is issued (RAM registers the address, then data is ready).
module ksa_engine #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned ADDR_W    = 8
) (
  input logic         clk,
  input logic         rst,
  ksa_engine_if.slave bus
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KidxLast = KW'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StRdI, StWtI, StRdJ, StWtJ, StWrI, StWrJ, StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] j_q;
  logic [ADDR_W-1:0] si_q;
  logic [KW-1:0]     kidx_q;  // i mod KEY_BYTES, wrapped alongside i
  logic              init_only_q;
  logic [7:0]        key_q [KEY_BYTES];  // key_q[0] is the most-significant key byte

  logic [7:0]          key_byte;
  logic [ADDR_W+7:0]   key_ext;
  logic [ADDR_W-1:0]   j_new;

  // Zero-extend then truncate so the key byte is reduced mod N for any ADDR_W.
  always_comb begin
    key_byte = key_q[kidx_q];
    key_ext  = {{ADDR_W{1'b0}}, key_byte};
    j_new    = j_q + bus.ram_q + key_ext[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      i_q           <= '0;
      j_q           <= '0;
      si_q          <= '0;
      kidx_q        <= '0;
      init_only_q   <= 1'b0;
      for (int unsigned k = 0; k < KEY_BYTES; k++) key_q[k] <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_wren  <= 1'b0;
    end else begin
      bus.ram_wren <= 1'b0;
      unique case (state_q)
        // Done behaves like idle for a new start; done stays high until then.
        StIdle, StDone: begin
          if (bus.start) begin
            for (int unsigned k = 0; k < KEY_BYTES; k++) begin
              key_q[k] <= bus.secret_key[8*(KEY_BYTES-1-k) +: 8];
            end
            init_only_q <= bus.init_only;
            i_q         <= '0;
            j_q         <= '0;
            kidx_q      <= '0;
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
            state_q     <= StInit;
          end
        end
        StInit: begin
          bus.ram_addr  <= i_q;
          bus.ram_wdata <= i_q;
          bus.ram_wren  <= 1'b1;
          if (&i_q) begin
            i_q <= '0;
            if (init_only_q) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q <= StRdI;
            end
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        StRdI: begin
          bus.ram_addr <= i_q;
          state_q      <= StWtI;
        end
        StWtI: state_q <= StRdJ;
        StRdJ: begin
          si_q         <= bus.ram_q;
          j_q          <= j_new;
          bus.ram_addr <= j_new;
          state_q      <= StWtJ;
        end
        StWtJ: state_q <= StWrI;
        StWrI: begin
          bus.ram_addr  <= i_q;
          bus.ram_wdata <= bus.ram_q;  // S[j]
          bus.ram_wren  <= 1'b1;
          state_q       <= StWrJ;
        end
        StWrJ: begin
          bus.ram_addr  <= j_q;
          bus.ram_wdata <= si_q;
          bus.ram_wren  <= 1'b1;
          if (&i_q) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state_q  <= StDone;
          end else begin
            i_q     <= i_q + 1'b1;
            kidx_q  <= (kidx_q == KidxLast) ? '0 : kidx_q + 1'b1;
            state_q <= StRdI;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: directed bench for ksa_engine with behavioural RAMs and a software KSA
// model. Main instance uses KEY_BYTES=3/ADDR_W=8; a second uses KEY_BYTES=1/ADDR_W=4.
module tb_ksa_engine;
  localparam int unsigned KB  = 3;
  localparam int unsigned AW  = 8;
  localparam int unsigned N   = 256;
  localparam int unsigned KB2 = 1;
  localparam int unsigned AW2 = 4;
  localparam int unsigned N2  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scramble = 1'b0;
  always #5 clk = ~clk;

  ksa_engine_if #(.KEY_BYTES(KB),  .ADDR_W(AW))  bus  ();
  ksa_engine_if #(.KEY_BYTES(KB2), .ADDR_W(AW2)) bus2 ();

  ksa_engine #(.KEY_BYTES(KB),  .ADDR_W(AW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  ksa_engine #(.KEY_BYTES(KB2), .ADDR_W(AW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // RAMs: address registered on the edge, data read combinationally from that register.
  logic [AW-1:0]  mem  [N];
  logic [AW2-1:0] mem2 [N2];
  logic [AW-1:0]  rd_q;
  logic [AW2-1:0] rd2_q;

  always @(posedge clk) begin
    if (scramble) begin
      for (int k = 0; k < N; k++) mem[k] <= 8'(k) ^ 8'h5A;
      for (int k = 0; k < N2; k++) mem2[k] <= 4'(k) ^ 4'hA;
    end else begin
      if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus2.ram_wren) mem2[bus2.ram_addr] <= bus2.ram_wdata;
    end
    rd_q  <= bus.ram_addr;
    rd2_q <= bus2.ram_addr;
  end

  always_comb begin
    bus.ram_q  = mem[rd_q];
    bus2.ram_q = mem2[rd2_q];
  end

  int total = 0;
  int bad = 0;
  int exp_s [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ksa_model(input int n, input int kbytes, input logic [127:0] key,
                           input bit init_only);
    int j, t, kb;
    for (int k = 0; k < n; k++) exp_s[k] = k;
    if (!init_only) begin
      j = 0;
      for (int i = 0; i < n; i++) begin
        kb = int'(key[8*(kbytes-1-(i%kbytes)) +: 8]);
        j = (j + exp_s[i] + kb) % n;
        t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic do_scramble();
    @(negedge clk); scramble = 1'b1;
    @(negedge clk); scramble = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge (cycle 0).
  task automatic do_start(input bit io, input logic [23:0] key);
    @(negedge clk);
    bus.init_only = io; bus.secret_key = key; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    int c = c0;
    lat = -1;
    while (c < 4000) begin
      if (bus.done === 1'b1) begin lat = c; break; end
      @(negedge clk); c++;
    end
  endtask

  task automatic check_ram(input string name);
    int errs = 0;
    for (int k = 0; k < N; k++) if (mem[k] !== 8'(exp_s[k])) errs++;
    check(name, errs, 0);
  endtask

  typedef struct {
    bit          init_only;
    logic [23:0] key;
    int          lat;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat, c, errs, io_bad, st_bad;
    vecs[0] = '{init_only: 1'b1, key: 24'h000000, lat: 256};
    vecs[1] = '{init_only: 1'b0, key: 24'h000000, lat: 1792};
    vecs[2] = '{init_only: 1'b0, key: 24'h000249, lat: 1792};
    vecs[3] = '{init_only: 1'b0, key: 24'hC0FFEE, lat: 1792};

    bus.start = 1'b0; bus.init_only = 1'b0; bus.secret_key = '0;
    bus2.start = 1'b0; bus2.init_only = 1'b0; bus2.secret_key = '0;
    tick(3);
    check("rst_state", {bus.busy, bus.done, bus.ram_wren, bus.ram_addr, bus.ram_wdata}, 0);
    check("rst_state2", {bus2.busy, bus2.done, bus2.ram_wren, bus2.ram_addr, bus2.ram_wdata},
          0);
    rst = 1'b0;

    // Small build: KEY_BYTES=1, ADDR_W=4, N=16 -> 16 + 96 cycles.
    do_scramble();
    @(negedge clk);
    bus2.secret_key = 8'h5A; bus2.init_only = 1'b0; bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    c = 0; lat = -1;
    while (c < 500) begin
      if (bus2.done === 1'b1) begin lat = c; break; end
      @(negedge clk); c++;
    end
    check("small_lat", lat, 112);
    tick(2);
    ksa_model(N2, KB2, 128'h5A, 1'b0);
    errs = 0;
    for (int k = 0; k < N2; k++) if (mem2[k] !== 4'(exp_s[k])) errs++;
    check("small_ram", errs, 0);

    // Init-only bus sequence: write k <- k on cycles 1..256, done at 256.
    do_scramble();
    do_start(1'b1, 24'h000000);
    io_bad = 0; st_bad = 0;
    for (int cy = 1; cy <= 256; cy++) begin
      @(negedge clk);
      if (bus.ram_wren !== 1'b1 || bus.ram_addr !== 8'(cy - 1) || bus.ram_wdata !== 8'(cy - 1))
        io_bad++;
      if (cy < 256 && (bus.busy !== 1'b1 || bus.done !== 1'b0)) st_bad++;
      if (cy == 256 && (bus.busy !== 1'b0 || bus.done !== 1'b1)) st_bad++;
    end
    check("init_writes", io_bad, 0);
    check("init_status", st_bad, 0);
    tick(2);
    check("init_wren_off", bus.ram_wren, 0);

    // Table of full / init-only runs, each restarting from DONE.
    for (int v = 0; v < 4; v++) begin
      do_scramble();
      do_start(vecs[v].init_only, vecs[v].key);
      wait_done(0, lat);
      check($sformatf("v%0d_lat", v), lat, vecs[v].lat);
      check($sformatf("v%0d_busy", v), bus.busy, 0);
      tick(3);
      check($sformatf("v%0d_done_held", v), bus.done, 1);
      ksa_model(N, KB, 128'(vecs[v].key), vecs[v].init_only);
      check_ram($sformatf("v%0d_ram", v));
      if (lat < 0) begin
        rst = 1'b1; tick(1); rst = 1'b0;
      end
    end

    // Key 0: trace RD_I for i=0 and the swap at i=2 (j=3).
    do_scramble();
    do_start(1'b0, 24'h000000);
    tick(257);
    check("rdi0", {bus.ram_wren, bus.ram_addr}, {1'b0, 8'd0});
    tick(16);
    check("wri2", {bus.ram_wren, bus.ram_addr, bus.ram_wdata}, {1'b1, 8'd2, 8'd3});
    tick(1);
    check("wrj2", {bus.ram_wren, bus.ram_addr, bus.ram_wdata}, {1'b1, 8'd3, 8'd2});
    wait_done(274, lat);
    check("swap_lat", lat, 1792);

    // Reset at cycle 900, then a fresh run over the partially written RAM.
    do_start(1'b0, 24'h123456);
    tick(900);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_out", {bus.busy, bus.done, bus.ram_wren, bus.ram_addr, bus.ram_wdata}, 0);
    tick(3);
    check("midrst_idle", {bus.busy, bus.done, bus.ram_wren}, 0);
    do_start(1'b0, 24'h000249);
    wait_done(0, lat);
    check("after_rst_lat", lat, 1792);
    tick(2);
    ksa_model(N, KB, 128'h000249, 1'b0);
    check_ram("after_rst_ram");

    // Start pulsed while busy (with other operands) is ignored.
    do_scramble();
    do_start(1'b0, 24'h0A0B0C);
    tick(50);
    bus.secret_key = 24'hFFFFFF; bus.init_only = 1'b1; bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("busy_ignore", {bus.busy, bus.done}, {1'b1, 1'b0});
    wait_done(51, lat);
    check("ignore_lat", lat, 1792);
    tick(2);
    ksa_model(N, KB, 128'h0A0B0C, 1'b0);
    check_ram("ignore_ram");

    // Start held in DONE restarts like idle.
    bus.secret_key = 24'h000249; bus.init_only = 1'b0; bus.start = 1'b1;
    tick(1);
    check("done_restart", {bus.busy, bus.done}, {1'b1, 1'b0});
    bus.start = 1'b0;
    wait_done(0, lat);
    check("restart_lat", lat, 1792);
    tick(2);
    ksa_model(N, KB, 128'h000249, 1'b0);
    check_ram("restart_ram");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ksa_engine.md
KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 Parameter KEY_BYTES, default 3: number of secret-key bytes, legal range 1..16.
REQ-002 Parameter ADDR_W, default 8: S-array address width; array depth N = 2**ADDR_W; data width = ADDR_W.
REQ-003 Ports and parameters SHALL be exactly those listed in REQ-001 to REQ-013.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  request to run; sampled only in IDLE.
REQ-007 init_only  in  1  sampled with start; 1 = fill S[k]=k only, skip the swap loop.
REQ-008 secret_key  in  8*KEY_BYTES  key; byte 0 = most-significant byte; sampled with start.
REQ-009 busy  out  1  high from the cycle after start is accepted until the cycle before DONE.
REQ-010 done  out  1  held high in DONE until the next accepted start or reset.
REQ-011 ram_addr  out  ADDR_W  single-port RAM address.
REQ-012 ram_wdata / ram_wren  out  ADDR_W / 1  write data and write enable.
REQ-013 ram_q  in  ADDR_W  RAM read data, valid two rising edges after ram_addr is driven (one wait state).

Function
REQ-014 The FSM SHALL have the states IDLE, INIT, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J and DONE.
REQ-015 IDLE SHALL accept start=1: latch secret_key and init_only, clear i and j to 0, and go to INIT.
REQ-016 INIT: one write per cycle, ram_addr=i, ram_wdata=i, ram_wren=1, for i=0..N-1 (N cycles).
REQ-017 After INIT, with i=N-1: if init_only, go to DONE; otherwise clear i to 0 and go to RD_I.
REQ-018 RD_I SHALL drive ram_addr=i with ram_wren=0, then WT_I SHALL hold ram_addr=i.
REQ-019 RD_J SHALL capture si=ram_q, compute j = (j + si + keybyte[i mod KEY_BYTES]) mod N, and drive ram_addr=new j.
REQ-020 WT_J SHALL hold ram_addr=j.
REQ-021 WR_I SHALL capture sj=ram_q and write S[i]=sj (ram_addr=i, ram_wren=1).
REQ-022 WR_J SHALL write S[j]=si; if i=N-1 go to DONE, else i=i+1 and go to RD_I.
REQ-023 The swap loop SHALL take exactly 6 cycles per i.
REQ-024 Full-run latency from the start-accept edge to done=1 SHALL be N + 6N cycles (1792 for ADDR_W=8); init_only latency SHALL be N cycles.
REQ-025 All index arithmetic SHALL wrap modulo N, and i mod KEY_BYTES SHALL be tracked with a separate wrapping counter (no divider).
REQ-026 When i=j, both writes SHALL occur and S SHALL remain unchanged.
REQ-027 start while busy or in DONE with start held SHALL be ignored except in DONE, where start=1 SHALL restart exactly as from IDLE.
REQ-028 ram_wren SHALL be 0 in every state except INIT, WR_I and WR_J.

Reset
REQ-029 rst=1 at a clock edge, in any state including mid-INIT or mid-swap, SHALL force IDLE with i=j=0, busy=0, done=0, ram_wren=0, ram_addr=0 and ram_wdata=0.
REQ-030 rst SHALL take priority over start; a partially written RAM is left as-is, and the next run re-initialises it.

Verification
REQ-031 init_only=1, start pulse -> 256 writes addr k <- k on consecutive cycles, then done=1 at cycle 256 and busy=0.
REQ-032 key=24'h000000, full run -> first non-trivial swap at i=2 (j=3): S[2]=3 and S[3]=2 written; final RAM matches a software KSA model; done at cycle 1792.
REQ-033 key=24'h000249, full run -> RAM equals the software KSA model for that key, byte order per REQ-008.
REQ-034 Assert rst at cycle 900 of a run, then start after release -> IDLE with outputs zeroed, fresh run completes correctly in 1792 cycles.
REQ-035 start pulsed during busy and held high in DONE -> first is ignored, second restarts; KEY_BYTES=1 and ADDR_W=4 build passes the model check.
